// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI master arbiter.
//   - arb_state_t   : arbiter FSM states (IDLE / GRANT / DRAIN)
//   - TimeoutWidth  : width of the optional grant-timeout counter
//   - clog2()       : index width helper for the requester count
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    localparam int TimeoutWidth = 16;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Searches req starting at (last+1) mod N upward with wrap and reports the
// first set bit.
//   req    in  N   : request vector
//   last   in  IW  : index granted most recently
//   onehot out N   : one-hot winner (zero when no request)
//   idx    out IW  : winner index (0 when no request)
//   valid  out 1   : at least one request present
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int          cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        onehot   = '0;
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= N; i++) begin
            cand = int'(last) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!valid && req[cand_idx]) begin
                valid            = 1'b1;
                idx              = cand_idx;
                onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin owner of a single SPI_Master shared by
// NumReq requester FSMs. One owner at a time; ownership changes only after
// the owner releases its request and the SPI_Master has finished shifting
// and drained its FIFO.
//
// Ports:
//   Clk_i, Reset_i (sync, active high)
//   Req_i / Grant_o                  : request / registered one-hot grant
//   ReqWrite_i, ReqReadNext_i,
//   ReqData_i, ReqCS_n_i,
//   ReqCPOL_i, ReqCPHA_i, ReqLSBFE_i : per-requester SPI command path
//   CS_n_o                           : per-device chip selects (active low)
//   SPI_Write_o, SPI_ReadNext_o,
//   SPI_Data_o                       : muxed command path to SPI_Master
//   SPI_CPOL_o, SPI_CPHA_o,
//   SPI_LSBFE_o                      : mode bits latched at grant time
//   SPI_Transmission_i,
//   SPI_FIFOEmpty_i                  : SPI_Master status for the drain
// Optional feature macro SPI_ARB_TIMEOUT_EN adds:
//   TimeoutPreset_i (16) : GRANT cycle budget, 0 disables
//   Timeout_o            : one-cycle pulse when a grant is revoked
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NumReq    = 2,
    parameter int DataWidth = 8
) (
    input  logic                          Clk_i,
    input  logic                          Reset_i,
    input  logic [NumReq-1:0]             Req_i,
    output logic [NumReq-1:0]             Grant_o,
    input  logic [NumReq-1:0]             ReqWrite_i,
    input  logic [NumReq-1:0]             ReqReadNext_i,
    input  logic [NumReq*DataWidth-1:0]   ReqData_i,
    input  logic [NumReq-1:0]             ReqCS_n_i,
    input  logic [NumReq-1:0]             ReqCPOL_i,
    input  logic [NumReq-1:0]             ReqCPHA_i,
    input  logic [NumReq-1:0]             ReqLSBFE_i,
    output logic [NumReq-1:0]             CS_n_o,
    output logic                          SPI_Write_o,
    output logic                          SPI_ReadNext_o,
    output logic [DataWidth-1:0]          SPI_Data_o,
    output logic                          SPI_CPOL_o,
    output logic                          SPI_CPHA_o,
    output logic                          SPI_LSBFE_o,
    input  logic                          SPI_Transmission_i,
    input  logic                          SPI_FIFOEmpty_i
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    input  logic [TimeoutWidth-1:0]       TimeoutPreset_i,
    output logic                          Timeout_o
`endif
);

    localparam int IW = clog2(NumReq);

    arb_state_t          state_reg, state_next;
    logic [NumReq-1:0]   grant_reg, grant_next;
    logic [IW-1:0]       last_reg, last_next;
    logic                cpol_reg, cpol_next;
    logic                cpha_reg, cpha_next;
    logic                lsbfe_reg, lsbfe_next;

    logic [NumReq-1:0]   pick_req;
    logic [NumReq-1:0]   pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                pick_valid;
    logic                release_now;

    logic [DataWidth-1:0] req_data [NumReq];

    // Unpack the flat data bus so the owner's word can be selected by index.
    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_data
            assign req_data[gi] = ReqData_i[gi*DataWidth +: DataWidth];
        end
    endgenerate

`ifdef SPI_ARB_TIMEOUT_EN
    logic [TimeoutWidth-1:0] cnt_reg, cnt_next;
    logic [NumReq-1:0]       mask_reg, mask_next;
    logic                    timeout_reg;
    logic                    timeout_fire;

    // A timed-out requester stays excluded until it lowers its request.
    assign pick_req  = Req_i & ~mask_reg;
    assign Timeout_o = timeout_reg;

    always_comb begin
        cnt_next     = cnt_reg;
        mask_next    = mask_reg & Req_i;
        timeout_fire = 1'b0;
        if (state_reg == ST_IDLE && pick_valid) begin
            cnt_next = TimeoutPreset_i;
        end else if (state_reg == ST_GRANT && cnt_reg != '0) begin
            // Counter value 1 marks the last permitted GRANT cycle; a zero
            // load never counts, which is what disables the timeout.
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == TimeoutWidth'(1)) begin
                timeout_fire        = 1'b1;
                mask_next[last_reg] = 1'b1;
            end
        end
    end

    assign release_now = !Req_i[last_reg] || timeout_fire;
`else
    assign pick_req    = Req_i;
    assign release_now = !Req_i[last_reg];
`endif

    rr_pick #(
        .N  (NumReq),
        .IW (IW)
    ) u_rr_pick (
        .req    (pick_req),
        .last   (last_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        cpol_next  = cpol_reg;
        cpha_next  = cpha_reg;
        lsbfe_next = lsbfe_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_GRANT;
                    grant_next = pick_onehot;
                    last_next  = pick_idx;
                    cpol_next  = ReqCPOL_i[pick_idx];
                    cpha_next  = ReqCPHA_i[pick_idx];
                    lsbfe_next = ReqLSBFE_i[pick_idx];
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!SPI_Transmission_i && SPI_FIFOEmpty_i) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    // Command path mux; last_reg holds the owner index while granted.
    always_comb begin
        SPI_Write_o    = 1'b0;
        SPI_ReadNext_o = 1'b0;
        SPI_Data_o     = '0;
        CS_n_o         = '1;
        if (state_reg == ST_GRANT) begin
            SPI_Write_o      = ReqWrite_i[last_reg];
            SPI_ReadNext_o   = ReqReadNext_i[last_reg];
            SPI_Data_o       = req_data[last_reg];
            CS_n_o[last_reg] = ReqCS_n_i[last_reg];
        end else if (state_reg == ST_DRAIN) begin
            SPI_Data_o       = req_data[last_reg];
            CS_n_o[last_reg] = ReqCS_n_i[last_reg];
        end
`ifdef SPI_ARB_TIMEOUT_EN
        if (mask_reg[last_reg]) begin
            CS_n_o[last_reg] = 1'b1;
        end
`endif
    end

    assign Grant_o     = grant_reg;
    assign SPI_CPOL_o  = cpol_reg;
    assign SPI_CPHA_o  = cpha_reg;
    assign SPI_LSBFE_o = lsbfe_reg;

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            last_reg  <= IW'(NumReq - 1);
            cpol_reg  <= 1'b0;
            cpha_reg  <= 1'b0;
            lsbfe_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
            cpol_reg  <= cpol_next;
            cpha_reg  <= cpha_next;
            lsbfe_reg <= lsbfe_next;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            cnt_reg     <= '0;
            mask_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            mask_reg    <= mask_next;
            timeout_reg <= timeout_fire;
        end
    end
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed testbench for spi_master_arbiter (NumReq=2, DataWidth=8).
// With SPI_ARB_TIMEOUT_EN defined the timeout scenario is also exercised.
module tb_spi_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, wr, rn, cs_req, cpol_in, cpha_in, lsbfe_in;
    logic [15:0] data_in;
    logic [1:0]  grant, cs_n;
    logic        spi_write, spi_rn, spi_cpol, spi_cpha, spi_lsbfe;
    logic [7:0]  spi_data;
    logic        trans, fifo_empty;
`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] preset;
    logic        timeout;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_master_arbiter #(.NumReq(2), .DataWidth(8)) dut (
        .Clk_i              (clk),
        .Reset_i            (rst),
        .Req_i              (req),
        .Grant_o            (grant),
        .ReqWrite_i         (wr),
        .ReqReadNext_i      (rn),
        .ReqData_i          (data_in),
        .ReqCS_n_i          (cs_req),
        .ReqCPOL_i          (cpol_in),
        .ReqCPHA_i          (cpha_in),
        .ReqLSBFE_i         (lsbfe_in),
        .CS_n_o             (cs_n),
        .SPI_Write_o        (spi_write),
        .SPI_ReadNext_o     (spi_rn),
        .SPI_Data_o         (spi_data),
        .SPI_CPOL_o         (spi_cpol),
        .SPI_CPHA_o         (spi_cpha),
        .SPI_LSBFE_o        (spi_lsbfe),
        .SPI_Transmission_i (trans),
        .SPI_FIFOEmpty_i    (fifo_empty)
`ifdef SPI_ARB_TIMEOUT_EN
        ,
        .TimeoutPreset_i    (preset),
        .Timeout_o          (timeout)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = 2'b00; wr = 2'b00; rn = 2'b00; cs_req = 2'b11;
        cpol_in = 2'b00; cpha_in = 2'b00; lsbfe_in = 2'b00;
        data_in = 16'h0000; trans = 1'b0; fifo_empty = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
        preset = 16'd0;
`endif
        do_reset();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
        total++; if (cs_n !== 2'b11) begin bad++; $display("FAIL reset_cs got=%b exp=11", cs_n); end
        total++; if ({spi_write, spi_rn, spi_data} !== 10'd0) begin bad++; $display("FAIL reset_cmd got=%b%b%h exp=0", spi_write, spi_rn, spi_data); end
        total++; if ({spi_cpol, spi_cpha, spi_lsbfe} !== 3'b000) begin bad++; $display("FAIL reset_mode got=%b%b%b exp=000", spi_cpol, spi_cpha, spi_lsbfe); end
        $display("txn reset done");
    endtask

    task automatic test_single();
        req = 2'b01; cs_req = 2'b10;
        tick();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", grant); end
        wr = 2'b01; data_in = 16'h0050;
        #1;
        total++; if (spi_write !== 1'b1) begin bad++; $display("FAIL single_write got=%b exp=1", spi_write); end
        total++; if (spi_data !== 8'h50) begin bad++; $display("FAIL single_data got=%h exp=50", spi_data); end
        total++; if (cs_n !== 2'b10) begin bad++; $display("FAIL single_cs got=%b exp=10", cs_n); end
        tick();
        wr = 2'b00; trans = 1'b1; fifo_empty = 1'b0; req = 2'b00;
        tick();
        wr = 2'b01;
        #1;
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL drain_grant got=%b exp=01", grant); end
        total++; if (spi_write !== 1'b0) begin bad++; $display("FAIL drain_write_forced got=%b exp=0", spi_write); end
        total++; if (cs_n !== 2'b10) begin bad++; $display("FAIL drain_cs got=%b exp=10", cs_n); end
        tick();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL drain_hold got=%b exp=01", grant); end
        wr = 2'b00; trans = 1'b0; fifo_empty = 1'b1;
        tick();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL drain_exit got=%b exp=00", grant); end
        total++; if (cs_n !== 2'b11) begin bad++; $display("FAIL idle_cs got=%b exp=11", cs_n); end
        cs_req = 2'b11; data_in = 16'h0000;
        $display("txn single requester0 data=50 done");
    endtask

    task automatic test_contention();
        logic [1:0] exp;
        do_reset();
        req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp = (t % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            total++; if (grant !== exp) begin bad++; $display("FAIL contention_grant t=%0d got=%b exp=%b", t, grant, exp); end
            req = 2'b11 & ~exp;
            tick();
            total++; if (grant !== exp) begin bad++; $display("FAIL contention_drain t=%0d got=%b exp=%b", t, grant, exp); end
            req = 2'b11;
            tick();
            total++; if (grant !== 2'b00) begin bad++; $display("FAIL contention_dead t=%0d got=%b exp=00", t, grant); end
            $display("txn contention t=%0d owner=%b", t, exp);
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_mode_switch();
        do_reset();
        cpol_in = 2'b01; cpha_in = 2'b01; lsbfe_in = 2'b10;
        req = 2'b01;
        tick();
        total++; if ({spi_cpol, spi_cpha, spi_lsbfe} !== 3'b110) begin bad++; $display("FAIL mode_r0 got=%b%b%b exp=110", spi_cpol, spi_cpha, spi_lsbfe); end
        req = 2'b00; trans = 1'b1; fifo_empty = 1'b0;
        cpol_in = 2'b00; cpha_in = 2'b00;
        tick();
        total++; if ({spi_cpol, spi_cpha} !== 2'b11) begin bad++; $display("FAIL mode_drain_hold got=%b%b exp=11", spi_cpol, spi_cpha); end
        trans = 1'b0; fifo_empty = 1'b1;
        tick();
        total++; if ({spi_cpol, spi_cpha} !== 2'b11) begin bad++; $display("FAIL mode_idle_hold got=%b%b exp=11", spi_cpol, spi_cpha); end
        req = 2'b10;
        tick();
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL mode_grant1 got=%b exp=10", grant); end
        total++; if ({spi_cpol, spi_cpha, spi_lsbfe} !== 3'b001) begin bad++; $display("FAIL mode_r1 got=%b%b%b exp=001", spi_cpol, spi_cpha, spi_lsbfe); end
        req = 2'b00;
        tick();
        tick();
        lsbfe_in = 2'b00;
        $display("txn mode switch done");
    endtask

    task automatic test_isolation_reset_mid();
        do_reset();
        cs_req = 2'b00; req = 2'b01;
        tick();
        wr = 2'b10;
        #1;
        total++; if (spi_write !== 1'b0) begin bad++; $display("FAIL iso_write_other got=%b exp=0", spi_write); end
        total++; if (cs_n !== 2'b10) begin bad++; $display("FAIL iso_cs got=%b exp=10", cs_n); end
        wr = 2'b11;
        #1;
        total++; if (spi_write !== 1'b1) begin bad++; $display("FAIL iso_write_owner got=%b exp=1", spi_write); end
        req = 2'b11;
        tick();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL iso_ignore got=%b exp=01", grant); end
        req = 2'b10;
        tick();
        wr = 2'b00;
        tick();
        tick();
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL iso_next_owner got=%b exp=10", grant); end
        $display("txn isolation done");
        // Reset while requester 1 owns the bus.
        wr = 2'b11; req = 2'b11; rst = 1'b1;
        tick();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rstmid_grant got=%b exp=00", grant); end
        total++; if (cs_n !== 2'b11) begin bad++; $display("FAIL rstmid_cs got=%b exp=11", cs_n); end
        total++; if ({spi_write, spi_cpol, spi_lsbfe} !== 3'b000) begin bad++; $display("FAIL rstmid_out got=%b%b%b exp=000", spi_write, spi_cpol, spi_lsbfe); end
        rst = 1'b0;
        tick();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL rstmid_first got=%b exp=01", grant); end
        req = 2'b00; wr = 2'b00; cs_req = 2'b11;
        tick();
        tick();
        $display("txn reset mid-grant done");
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        preset = 16'd5; cs_req = 2'b10; req = 2'b01;
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (timeout !== 1'b0 || grant !== 2'b01) begin bad++; $display("FAIL to_early c=%0d to=%b grant=%b", c, timeout, grant); end
        end
        tick();
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b exp=1", timeout); end
        total++; if (cs_n !== 2'b11) begin bad++; $display("FAIL to_cs got=%b exp=11", cs_n); end
        tick();
        total++; if (timeout !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL to_end to=%b grant=%b exp=0/00", timeout, grant); end
        tick();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL to_masked got=%b exp=00", grant); end
        req = 2'b00;
        tick();
        req = 2'b01;
        tick();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL to_regrant got=%b exp=01", grant); end
        $display("txn timeout done");
    endtask
`endif

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_mode_switch();
        test_isolation_reset_mid();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Round-robin controller sharing the single SPI_Master between `NumReq` requester FSMs, for example an ADT7310 SPIFSM and a second sensor FSM. It grants exclusive use of the SPI command path (Write, ReadNext, Data, mode bits) to one requester at a time. It drives one chip select per requester and never switches owner while a transfer or FIFO drain is in flight. It sits between the requester FSMs and the SPI_Master inside the reconfigurable module.

## Interface
- `NumReq`, default 2: number of requesters, range 2..8.
- `DataWidth`, default 8: SPI data width.
- `Clk_i` in, 1: single clock, rising edge.
- `Reset_i` in, 1: synchronous, active-high reset.
- `Req_i` in, NumReq: request per requester; level-held for the whole transaction.
- `Grant_o` out, NumReq: one-hot or zero; registered.
- `ReqWrite_i` in, NumReq: per-requester SPI_Write.
- `ReqReadNext_i` in, NumReq: per-requester SPI_ReadNext.
- `ReqData_i` in, NumReq*DataWidth: per-requester write data; requester k occupies bits [k*DataWidth +: DataWidth].
- `ReqCS_n_i` in, NumReq: per-requester chip-select request, active low.
- `ReqCPOL_i`, `ReqCPHA_i`, `ReqLSBFE_i` in, NumReq each: per-requester SPI mode bits.
- `CS_n_o` out, NumReq: device chip selects, active low.
- `SPI_Write_o`, `SPI_ReadNext_o` out, 1: to SPI_Master.
- `SPI_Data_o` out, DataWidth: to SPI_Master.
- `SPI_CPOL_o`, `SPI_CPHA_o`, `SPI_LSBFE_o` out, 1: registered mode bits to SPI_Master.
- `SPI_Transmission_i`, `SPI_FIFOEmpty_i` in, 1: SPI_Master status. SPI_Data_i, FIFOFull and the other status signals go straight to all requesters and do not pass through this block.

## Operation
- State machine: IDLE, GRANT, DRAIN.
- IDLE:
  - If any `Req_i` bit is set, pick the first set bit searching from `(Last+1) mod NumReq` upward with wrap.
  - On the next edge: go to GRANT, set `Grant_o[k]`, `Last <= k`, and latch requester k's CPOL/CPHA/LSBFE into the mode registers.
- GRANT:
  - `SPI_Write_o`, `SPI_ReadNext_o` and `SPI_Data_o` are combinational copies of the granted requester's inputs.
  - `CS_n_o[k] = ReqCS_n_i[k]`; all other `CS_n_o` bits are 1.
  - Requests from other requesters are ignored.
  - When `Req_i[k]` falls, go to DRAIN.
- DRAIN:
  - `Grant_o` stays set and `CS_n_o[k]` still follows the requester.
  - `SPI_Write_o` and `SPI_ReadNext_o` are forced to 0.
  - When `SPI_Transmission_i==0 && SPI_FIFOEmpty_i==1`, go to IDLE and clear `Grant_o`.
- Outside GRANT/DRAIN: Write, ReadNext and Data are 0 and all `CS_n_o` are 1.
- Mode bits change only on the IDLE→GRANT edge and otherwise hold their value.
- Reset values:
  - `Grant_o` = 0, `CS_n_o` = all 1.
  - Write, ReadNext, Data = 0; CPOL, CPHA, LSBFE = 0.
  - State = IDLE, `Last = NumReq-1`, so requester 0 wins the first round.
- Reset asserted mid-transfer returns to the reset values on the next edge. SPI_Master shares this reset, so no drain is needed.

## Timing
- Request to grant: `Req_i` sampled high in IDLE gives `Grant_o` high 1 cycle later.
- Release: `Req_i` low in GRANT gives DRAIN on the next edge. The transition out of DRAIN clears `Grant_o` on the edge where the drain condition is sampled true.
- Ownership change: at least 1 cycle in IDLE between owners, so back-to-back grants are spaced by 1 dead cycle.
- Simultaneous requests: exactly one winner, chosen by the round-robin pointer. No requester waits more than NumReq-1 grants.
- A requester that drops `Req_i` in the same cycle it is granted still passes through DRAIN for at least 1 cycle.

## Configuration
- Macro: `SPI_ARB_TIMEOUT_EN`.
- With the macro defined:
  - Adds `TimeoutPreset_i` (in, 16 bits) and `Timeout_o` (out, 1 bit, one-cycle pulse).
  - A counter loads the preset on entry to GRANT and decrements once per GRANT cycle.
  - At 0 it forces DRAIN, pulses `Timeout_o`, forces `CS_n_o[k]` to 1, and masks requester k until its `Req_i` goes low.
  - A preset of 0 disables the timeout.
- Without the macro: no counter, no ports; a grant lasts until the requester releases it.

## Structure
- Package `spi_arb_pkg`:
  - State enum (IDLE/GRANT/DRAIN).
  - Index width function `clog2(NumReq)`.
  - Timeout counter width constant (16).
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs are a request vector and the last-granted index; outputs are a one-hot vector and an index. It is instantiated once.

## Test plan
- Single request: Req_i=01 → Grant_o=01 one cycle later. Requester 0 writes 0x50 and the byte appears on SPI_Data_o with CS_n_o=10. Req drops while Transmission=1, so Grant holds. Transmission=0 and FIFOEmpty=1 → Grant_o=00 on the next edge.
- Contention: Req_i=11 held for 4 transactions → grants alternate 0,1,0,1 with 1 IDLE cycle between each.
- Mode switch: requester 0 has CPOL/CPHA=1/1, requester 1 has 0/0. Mode outputs change only on the grant edge and never during DRAIN.
- Isolation: requester 1 toggles ReqWrite while requester 0 is granted → SPI_Write_o follows requester 0 only and CS_n_o[1] stays 1.
- Reset mid-GRANT: all outputs return to reset values next cycle; the first grant afterwards goes to requester 0.
- `SPI_ARB_TIMEOUT_EN` defined, TimeoutPreset=5, requester holds Req → Timeout_o pulses after 5 GRANT cycles, CS_n_o goes high, and the requester is not regranted until its Req falls.
